// File: rtl/exec_mem_ctrl.sv
// Sequences exec data and fetch accesses onto one 16-bit ack bus; splits unaligned words in two byte cycles.
// Latency: 2 cycles aligned/byte, 3 unaligned with zero-wait ack; waits indefinitely on bus_ack, stalls exec via block.
module exec_mem_ctrl #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_req,
   input  logic [19:0] ex_addr,
   input  logic [15:0] ex_wr_data,
   input  logic        ex_we,
   input  logic        ex_m_io,
   input  logic        ex_byteop,
   output logic [15:0] ex_rd_data,
   output logic        block,
   input  logic        if_req,
   input  logic [19:0] if_addr,
   output logic [15:0] if_data,
   output logic        if_ack,
   output logic [18:0] bus_adr,
   output logic [15:0] bus_dat_o,
   input  logic [15:0] bus_dat_i,
   output logic [1:0]  bus_sel,
   output logic        bus_we,
   output logic        bus_tga,
   output logic        bus_stb,
   input  logic        bus_ack
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, X1, X2} state_t;

   state_t        state;
   logic          owner_if;
   logic          split;
   logic          byteop;
   logic [7:0]    lo_byte;
   logic [7:0]    hi_wr;
   logic [18:0]   x2_adr;
   logic [CW-1:0] starve_cnt;

   logic          fetch_win;
   logic          ex_win;
   logic [19:0]   g_addr;
   logic [19:0]   g_addr_p1;
   logic          g_byte;
   logic          g_split;
   logic [1:0]    g_sel;
   logic [15:0]   g_dat;
   logic          done;
   logic [15:0]   rd_mux;

   always_comb begin
      fetch_win = if_req && (!ex_req || starve_cnt == SMAX);
      ex_win    = ex_req && !fetch_win;
      g_addr    = fetch_win ? if_addr : ex_addr;
      g_addr_p1 = g_addr + 20'd1;
      g_byte    = ex_win && ex_byteop;
      g_split   = !g_byte && g_addr[0];
      if (g_byte)
         g_sel = g_addr[0] ? 2'b10 : 2'b01;
      else if (g_split)
         g_sel = 2'b10;
      else
         g_sel = 2'b11;
      // Byte and first split half carry the low write byte on both lanes
      if (!ex_win)
         g_dat = 16'h0000;
      else if (g_byte || g_split)
         g_dat = {ex_wr_data[7:0], ex_wr_data[7:0]};
      else
         g_dat = ex_wr_data;
   end

   assign done = bus_ack && ((state == X1 && !split) || state == X2);

   always_comb begin
      rd_mux = bus_dat_i;
      if (byteop)
         rd_mux = {8'h00, bus_sel[1] ? bus_dat_i[15:8] : bus_dat_i[7:0]};
      else if (split)
         rd_mux = {bus_dat_i[7:0], lo_byte};
   end

   assign ex_rd_data = rd_mux;
   assign if_data    = rd_mux;
   assign if_ack     = done && owner_if;
   assign block      = ex_req && !(done && !owner_if);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         owner_if   <= 1'b0;
         split      <= 1'b0;
         byteop     <= 1'b0;
         lo_byte    <= 8'h00;
         hi_wr      <= 8'h00;
         x2_adr     <= 19'h0;
         starve_cnt <= '0;
         bus_adr    <= 19'h0;
         bus_dat_o  <= 16'h0000;
         bus_sel    <= 2'b00;
         bus_we     <= 1'b0;
         bus_tga    <= 1'b0;
         bus_stb    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fetch_win || ex_win) begin
                  state     <= X1;
                  bus_stb   <= 1'b1;
                  owner_if  <= fetch_win;
                  split     <= g_split;
                  byteop    <= g_byte;
                  bus_adr   <= g_addr[19:1];
                  x2_adr    <= g_addr_p1[19:1];
                  bus_sel   <= g_sel;
                  bus_dat_o <= g_dat;
                  bus_we    <= ex_win && ex_we;
                  bus_tga   <= ex_win && ex_m_io;
                  hi_wr     <= ex_wr_data[15:8];
                  if (fetch_win)
                     starve_cnt <= '0;
                  else if (if_req && starve_cnt != SMAX)
                     starve_cnt <= starve_cnt + CW'(1);
               end
            end
            X1: begin
               if (bus_ack) begin
                  if (split) begin
                     state     <= X2;
                     lo_byte   <= bus_dat_i[15:8];
                     bus_adr   <= x2_adr;
                     bus_sel   <= 2'b01;
                     bus_dat_o <= {hi_wr, hi_wr};
                  end else begin
                     state   <= IDLE;
                     bus_stb <= 1'b0;
                     bus_we  <= 1'b0;
                     bus_tga <= 1'b0;
                  end
               end
            end
            X2: begin
               if (bus_ack) begin
                  state   <= IDLE;
                  bus_stb <= 1'b0;
                  bus_we  <= 1'b0;
                  bus_tga <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_mem_ctrl.sv
// Directed bench for exec_mem_ctrl: vector table of exec accesses plus starvation and reset sequences.
module tb_exec_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_req;
   logic [19:0] ex_addr;
   logic [15:0] ex_wr_data;
   logic        ex_we;
   logic        ex_m_io;
   logic        ex_byteop;
   logic [15:0] ex_rd_data;
   logic        block;
   logic        if_req;
   logic [19:0] if_addr;
   logic [15:0] if_data;
   logic        if_ack;
   logic [18:0] bus_adr;
   logic [15:0] bus_dat_o;
   logic [15:0] bus_dat_i;
   logic [1:0]  bus_sel;
   logic        bus_we;
   logic        bus_tga;
   logic        bus_stb;
   logic        bus_ack;

   int total = 0;
   int bad   = 0;

   exec_mem_ctrl #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .ex_req(ex_req), .ex_addr(ex_addr), .ex_wr_data(ex_wr_data), .ex_we(ex_we),
      .ex_m_io(ex_m_io), .ex_byteop(ex_byteop), .ex_rd_data(ex_rd_data), .block(block),
      .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack),
      .bus_adr(bus_adr), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_sel(bus_sel),
      .bus_we(bus_we), .bus_tga(bus_tga), .bus_stb(bus_stb), .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] addr;
      logic        we;
      logic        io;
      logic        bo;
      logic [15:0] wd;
      int          waits;
      logic        split;
      logic [15:0] rd1;
      logic [15:0] rd2;
      logic [18:0] adr1;
      logic [1:0]  sel1;
      logic [15:0] dmask1;
      logic [15:0] dexp1;
      logic [18:0] adr2;
      logic [1:0]  sel2;
      logic [15:0] dmask2;
      logic [15:0] dexp2;
      logic        chk_rd;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      @(negedge clk);
      ex_req = 1'b1; ex_addr = v.addr; ex_we = v.we; ex_m_io = v.io;
      ex_byteop = v.bo; ex_wr_data = v.wd; bus_ack = 1'b0;
      #1;
      chk({tag, ".req_block"}, block, 1'b1);
      chk({tag, ".req_stb"}, bus_stb, 1'b0);
      @(negedge clk);
      chk({tag, ".stb1"}, bus_stb, 1'b1);
      chk({tag, ".adr1"}, bus_adr, v.adr1);
      chk({tag, ".sel1"}, bus_sel, v.sel1);
      chk({tag, ".dat1"}, bus_dat_o & v.dmask1, v.dexp1);
      chk({tag, ".we"}, bus_we, v.we);
      chk({tag, ".tga"}, bus_tga, v.io);
      for (int w = 0; w < v.waits; w++) begin
         #1;
         chk({tag, ".wait_block"}, block, 1'b1);
         @(negedge clk);
         chk({tag, ".wait_stb"}, bus_stb, 1'b1);
      end
      bus_ack = 1'b1; bus_dat_i = v.rd1;
      #1;
      if (v.split) begin
         chk({tag, ".x1_block"}, block, 1'b1);
         @(negedge clk);
         bus_dat_i = v.rd2;
         chk({tag, ".stb2"}, bus_stb, 1'b1);
         chk({tag, ".adr2"}, bus_adr, v.adr2);
         chk({tag, ".sel2"}, bus_sel, v.sel2);
         chk({tag, ".dat2"}, bus_dat_o & v.dmask2, v.dexp2);
         #1;
      end
      chk({tag, ".done_block"}, block, 1'b0);
      if (v.chk_rd) chk({tag, ".rd"}, ex_rd_data, v.exp_rd);
      @(negedge clk);
      bus_ack = 1'b0; ex_req = 1'b0;
      chk({tag, ".idle_stb"}, bus_stb, 1'b0);
   endtask

   logic exp_pat[10];
   logic got_pat[10];
   int   ncomp;

   initial begin
      rst = 1'b0; ex_req = 1'b0; ex_addr = '0; ex_wr_data = '0; ex_we = 1'b0;
      ex_m_io = 1'b0; ex_byteop = 1'b0; if_req = 1'b0; if_addr = '0;
      bus_dat_i = '0; bus_ack = 1'b0;

      //           addr     we   io   bo   wd       wt sp  rd1      rd2      adr1      sel1   dmask1   dexp1    adr2      sel2   dmask2   dexp2    chk  exp_rd
      vecs[0] = '{20'h12344, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 16'hBEEF, 16'h0000, 19'h091A2, 2'b11, 16'h0000, 16'h0000, 19'h0, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
      vecs[1] = '{20'h00101, 1'b1, 1'b0, 1'b0, 16'hA55A, 0, 1'b1, 16'h0000, 16'h0000, 19'h00080, 2'b10, 16'hFF00, 16'h5A00, 19'h00081, 2'b01, 16'h00FF, 16'h00A5, 1'b0, 16'h0000};
      vecs[2] = '{20'h00003, 1'b0, 1'b0, 1'b1, 16'h0000, 2, 1'b0, 16'h7711, 16'h0000, 19'h00001, 2'b10, 16'h0000, 16'h0000, 19'h0, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0077};
      vecs[3] = '{20'hFFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h3300, 16'h0044, 19'h7FFFF, 2'b10, 16'h0000, 16'h0000, 19'h00000, 2'b01, 16'h0000, 16'h0000, 1'b1, 16'h4433};
      vecs[4] = '{20'h00200, 1'b1, 1'b1, 1'b1, 16'h00C3, 0, 1'b0, 16'h0000, 16'h0000, 19'h00100, 2'b01, 16'hFFFF, 16'hC3C3, 19'h0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      vecs[5] = '{20'h00010, 1'b1, 1'b1, 1'b0, 16'h1234, 1, 1'b0, 16'h0000, 16'h0000, 19'h00008, 2'b11, 16'hFFFF, 16'h1234, 19'h0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      vecs[6] = '{20'h00004, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 16'h7711, 16'h0000, 19'h00002, 2'b01, 16'h0000, 16'h0000, 19'h0, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0011};

      repeat (2) @(negedge clk);
      chk("rst.stb", bus_stb, 1'b0);
      chk("rst.we", bus_we, 1'b0);
      chk("rst.tga", bus_tga, 1'b0);
      chk("rst.adr", bus_adr, 19'h0);
      chk("rst.sel", bus_sel, 2'b00);
      chk("rst.dat", bus_dat_o, 16'h0000);
      chk("rst.if_ack", if_ack, 1'b0);
      chk("rst.block", block, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle.stb", bus_stb, 1'b0);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Starvation: both requesters held; expect 4 exec completions then one fetch, repeating
      for (int i = 0; i < 10; i++) exp_pat[i] = (i == 4 || i == 9);
      @(negedge clk);
      ex_req = 1'b1; ex_addr = 20'h00020; ex_we = 1'b0; ex_m_io = 1'b0; ex_byteop = 1'b0;
      if_req = 1'b1; if_addr = 20'h00400;
      ncomp = 0;
      for (int cyc = 0; cyc < 200 && ncomp < 10; cyc++) begin
         @(negedge clk);
         bus_ack = bus_stb;
         bus_dat_i = 16'h1000 + 16'(cyc);
         #1;
         if (bus_stb) begin
            got_pat[ncomp] = if_ack;
            if (if_ack) begin
               chk($sformatf("starve.if_adr%0d", ncomp), bus_adr, 19'h00200);
               chk($sformatf("starve.if_data%0d", ncomp), if_data, 16'h1000 + 16'(cyc));
               chk($sformatf("starve.if_blk%0d", ncomp), block, 1'b1);
            end else begin
               chk($sformatf("starve.ex_blk%0d", ncomp), block, 1'b0);
            end
            ncomp++;
         end
      end
      if (ncomp < 10) begin
         bad++; total++;
         $display("FAIL starve.timeout: got %0d completions want 10", ncomp);
      end
      for (int i = 0; i < ncomp; i++)
         chk($sformatf("starve.owner%0d", i), got_pat[i], exp_pat[i]);
      @(negedge clk);
      ex_req = 1'b0; if_req = 1'b0; bus_ack = 1'b0;
      @(negedge clk);

      // Reset during the second half of a split read
      ex_req = 1'b1; ex_addr = 20'h00011; ex_byteop = 1'b0; ex_we = 1'b0;
      @(negedge clk);
      bus_ack = 1'b1; bus_dat_i = 16'h5500;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("rstx2.stb_before", bus_stb, 1'b1);
      chk("rstx2.adr_before", bus_adr, 19'h00009);
      rst = 1'b0;
      #1;
      chk("rstx2.stb", bus_stb, 1'b0);
      chk("rstx2.adr", bus_adr, 19'h0);
      chk("rstx2.sel", bus_sel, 2'b00);
      chk("rstx2.block", block, 1'b1);
      @(negedge clk);
      ex_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_vec(vecs[0], "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exec_mem_ctrl.md
Name: exec_mem_ctrl

Overview:
Memory/I-O bus sequencer between the execution unit's data port, the instruction fetch unit and a single 16-bit external bus with ack handshake. It arbitrates the two requesters and splits unaligned word accesses into two byte cycles. It drives the execution unit's `block` stall input and `memout` read data.

Parameters:
STARVE_MAX, 4, consecutive exec grants allowed while fetch is waiting before fetch is forced through.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
ex_req  in  1  exec data access request; held stable until block low
ex_addr  in  20  exec byte address (aluout[19:0])
ex_wr_data  in  16  exec write data
ex_we  in  1  exec write
ex_m_io  in  1  1 = I/O space
ex_byteop  in  1  1 = byte access
ex_rd_data  out  16  read data to exec (memout)
block  out  1  stall to exec
if_req  in  1  fetch request (always word, memory space); held until if_ack
if_addr  in  20  fetch byte address
if_data  out  16  fetch data, valid with if_ack
if_ack  out  1  one-cycle fetch completion pulse
bus_adr  out  19  word address [19:1]
bus_dat_o  out  16  write data
bus_dat_i  in  16  read data
bus_sel  out  2  byte lane select, bit1 = odd byte
bus_we  out  1  write
bus_tga  out  1  1 = I/O cycle
bus_stb  out  1  cycle strobe
bus_ack  in  1  cycle done; ignored while bus_stb = 0

Behaviour:
- Reset (rst = 0, async): state IDLE. bus_stb, bus_we, bus_tga, if_ack = 0. bus_adr, bus_sel, bus_dat_o, lo-byte latch, starve count = 0.
- Reset mid-transaction aborts at once; no completion is reported.
- States: IDLE, X1 (first/only half), X2 (second half of unaligned word).
- Owner bit records exec or fetch.
- IDLE: grant decided from requests in that cycle. Bus outputs are registered; bus_stb = 1 from the next cycle.
- Grant priority: exec over fetch, except fetch wins when starve count = STARVE_MAX and if_req = 1.
- Starve count increments on each exec grant made while if_req = 1, saturates at STARVE_MAX, and clears on every fetch grant.
- Access decode, address A:
  - Byte: one cycle. bus_sel = A[0] ? 10 : 01. Write byte replicated on both lanes.
  - Aligned word: one cycle, sel = 11.
  - Unaligned word: X1 = adr A[19:1], sel 10, low byte on [15:8]. X2 = adr (A+1)[19:1], sel 01, high byte on [7:0].
  - A+1 wraps modulo 2^20 (0xFFFFF -> 0x00000).
  - Unaligned rule applies to I/O and fetch too.
- X1 with bus_ack:
  - Split access: latch bus_dat_i[15:8] as low byte and go to X2. bus_stb stays 1 and bus_adr/sel update next cycle.
  - Otherwise: complete.
- X2 with bus_ack: complete. X1/X2 wait indefinitely for ack.
- Completion cycle: bus_stb = 0 next cycle and the state returns to IDLE. At least one idle bus cycle between transactions.
- Read data valid only in the completion cycle (combinational from bus_dat_i):
  - Byte: selected lane in [7:0], [15:8] = 00.
  - Aligned word: bus_dat_i.
  - Split: {bus_dat_i[7:0], latched low}.
- if_ack = 1 only in a fetch completion cycle.
- block = ex_req AND NOT (exec completion this cycle). Exec samples ex_rd_data when block falls.
- ex_req = 0 gives block = 0.
- A transaction is atomic once granted; both halves complete before re-arbitration.
- Minimum latency: request cycle + one bus cycle with zero-wait ack = 2 cycles. Unaligned minimum = 3.

Test Plan:
- Aligned word read:
  - Stimulus: ex_req, addr 0x12344, ack the first strobe cycle, bus_dat_i = 0xBEEF.
  - Required: bus_adr = 0x091A2, sel 11; block high 1 cycle then low; ex_rd_data = 0xBEEF in the ack cycle.
- Unaligned word write:
  - Stimulus: addr 0x00101, data 0xA55A.
  - Required: cycle 1 adr 0x00080, sel 10, dat_o[15:8] = 5A; cycle 2 adr 0x00081, sel 01, dat_o[7:0] = A5; block low only on the second ack.
- Byte read:
  - Stimulus: odd addr 0x00003, bus_dat_i = 0x7711.
  - Required: sel 10; ex_rd_data = 0x0077.
- Wrap:
  - Stimulus: unaligned read at 0xFFFFF, acks return 0x3300 then 0x0044.
  - Required: second cycle adr 0x00000; result 0x4433.
- Starvation:
  - Stimulus: ex_req and if_req held continuously, STARVE_MAX = 4.
  - Required: 4 exec grants, then one fetch (if_ack pulse), counter cleared, exec resumes.
- Reset:
  - Stimulus: rst low during X2 of a split access.
  - Required: bus_stb = 0 immediately; after release the state is IDLE and a fresh exec request completes normally.
